// File: rtl/rvj1_sram_port_arbiter.sv
// ============================================================================
// Module      : rvj1_sram_port_arbiter
// Description : Round-robin sharing of one SRAM port between the core and a
//               Wishbone slave; Wishbone-only mode locks the core out.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rvj1_sram_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  wb_only_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [DATA_W/8-1:0]   cpu_be_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [DATA_W-1:0]     cpu_wdata_i,
  output logic                  cpu_gnt_o,
  output logic                  cpu_rvalid_o,
  output logic [DATA_W-1:0]     cpu_rdata_o,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [DATA_W/8-1:0]   wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DATA_W-1:0]     wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_W-1:0]     wbs_dat_o,
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [DATA_W/8-1:0]   sram_wmask0_o,
  output logic [ADDR_W-1:0]     sram_addr0_o,
  output logic [DATA_W-1:0]     sram_din0_o,
  input  logic [DATA_W-1:0]     sram_dout0_i
);

  localparam int c_BE_W = DATA_W / 8;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_WB  = 1'b1
  } gnt_e;

  gnt_e r_last_gnt;
  logic r_wb_pend;
  logic r_cpu_rvalid;
  logic r_cpu_rd;
  logic r_wb_ack;
  logic r_wb_rd;

  logic              w_cpu_ok;
  logic              w_wb_ok;
  logic              w_cpu_win;
  logic              w_wb_win;
  logic [ADDR_W-1:0] w_wb_addr;
  logic              w_unused;

  assign w_wb_addr = wbs_adr_i[ADDR_W+1:2];
  assign w_unused  = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

  // Gating with rstn_i keeps the SRAM idle and cpu_gnt_o low during reset.
  always_comb begin
    w_cpu_ok  = cpu_req_i & ~wb_only_i & rstn_i;
    w_wb_ok   = wbs_cyc_i & wbs_stb_i & ~r_wb_pend & rstn_i;
    w_cpu_win = w_cpu_ok & (~w_wb_ok | (r_last_gnt == GNT_WB));
    w_wb_win  = w_wb_ok & ~w_cpu_win;
  end

  always_comb begin
    sram_csb0_o   = 1'b1;
    sram_web0_o   = 1'b1;
    sram_wmask0_o = '0;
    sram_addr0_o  = '0;
    sram_din0_o   = '0;
    if (w_cpu_win) begin
      sram_csb0_o   = 1'b0;
      sram_web0_o   = ~cpu_we_i;
      sram_wmask0_o = cpu_we_i ? cpu_be_i : {c_BE_W{1'b1}};
      sram_addr0_o  = cpu_addr_i;
      sram_din0_o   = cpu_wdata_i;
    end else if (w_wb_win) begin
      sram_csb0_o   = 1'b0;
      sram_web0_o   = ~wbs_we_i;
      sram_wmask0_o = wbs_we_i ? wbs_sel_i : {c_BE_W{1'b1}};
      sram_addr0_o  = w_wb_addr;
      sram_din0_o   = wbs_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_last_gnt   <= GNT_WB;
      r_wb_pend    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_cpu_rd     <= 1'b0;
      r_wb_ack     <= 1'b0;
      r_wb_rd      <= 1'b0;
    end else begin
      if (w_cpu_win) begin
        r_last_gnt <= GNT_CPU;
      end else if (w_wb_win) begin
        r_last_gnt <= GNT_WB;
      end
      // Pending flag blocks a second grant for the stb being acknowledged.
      r_wb_pend    <= w_wb_win;
      r_cpu_rvalid <= w_cpu_win;
      r_cpu_rd     <= w_cpu_win & ~cpu_we_i;
      r_wb_ack     <= w_wb_win;
      r_wb_rd      <= w_wb_win & ~wbs_we_i;
    end
  end

  assign cpu_gnt_o    = w_cpu_win;
  assign cpu_rvalid_o = r_cpu_rvalid;
  assign cpu_rdata_o  = r_cpu_rd ? sram_dout0_i : '0;
  assign wbs_ack_o    = r_wb_ack;
  assign wbs_dat_o    = r_wb_rd ? sram_dout0_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_rvj1_sram_port_arbiter.sv
// ============================================================================
// Module      : tb_rvj1_sram_port_arbiter
// Description : Directed self-checking bench with a behavioural SRAM model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rvj1_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_only = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0]  cpu_be = 4'h0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'h0;
  logic [31:0] wb_adr = '0, wb_wdat = '0;
  logic        wb_ack;
  logic [31:0] wb_rdat;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0 = '0;

  int n_checks = 0;
  int n_errors = 0;
  int n_rv = 0;
  int n_ack = 0;

  logic [31:0] mem [512];

  always #5 clk = ~clk;

  rvj1_sram_port_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk_i(clk), .rstn_i(rst_n), .wb_only_i(wb_only),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_be_i(cpu_be),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb), .wbs_we_i(wb_we),
    .wbs_sel_i(wb_sel), .wbs_adr_i(wb_adr), .wbs_dat_i(wb_wdat),
    .wbs_ack_o(wb_ack), .wbs_dat_o(wb_rdat),
    .sram_csb0_o(csb0), .sram_web0_o(web0), .sram_wmask0_o(wmask0),
    .sram_addr0_o(addr0), .sram_din0_o(din0), .sram_dout0_i(dout0)
  );

  // Behavioural sky130 macro: registered read data, byte-masked writes.
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cpu_rvalid) n_rv++;
    if (wb_ack) n_ack++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 1'b1;
    #2;
    chk("rst_gnt", cpu_gnt, 0);
    chk("rst_csb", csb0, 1);
    chk("rst_web", web0, 1);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_ack", wb_ack, 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cpu_acc(input logic we, input logic [8:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd);
    logic got = 1'b0;
    int n = 0;
    rd = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
    while (!got && n < 20) begin
      #1;
      got = cpu_gnt;
      @(posedge clk);
      #1;
      if (got) begin
        cpu_req = 1'b0;
        chk("cpu_rvalid", cpu_rvalid, 1);
        rd = cpu_rdata;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    cpu_req = 1'b0;
    if (!got) chk("cpu_timeout", 0, 1);
  endtask

  task automatic wb_acc(input logic we, input logic [8:0] a, input logic [31:0] wd,
                        input logic [3:0] sel, output logic [31:0] rd);
    logic got = 1'b0;
    int n = 0;
    rd = '0;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = 32'h3000_0000 | {21'd0, a, 2'b00};
    wb_wdat = wd; wb_sel = sel;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      got = wb_ack;
      if (got) rd = wb_rdat;
      else n++;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    if (!got) chk("wb_timeout", 0, 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] sb_cpu [16];
    logic [31:0] sb_wb [16];
    bit exp_g [6] = '{1, 0, 1, 0, 1, 0};
    int rv0, ack0;

    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) begin sb_cpu[i] = '0; sb_wb[i] = '0; end
    mem[9'h010] = 32'hDEAD_BEEF;

    do_reset();

    // Core read with same-cycle grant and next-cycle data.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010;
    #1;
    chk("t1_gnt", cpu_gnt, 1);
    chk("t1_csb", csb0, 0);
    chk("t1_web", web0, 1);
    chk("t1_addr", addr0, 9'h010);
    chk("t1_wmask", wmask0, 4'hF);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    chk("t1_rvalid", cpu_rvalid, 1);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("t1_rvalid_off", cpu_rvalid, 0);
    chk("t1_rdata_off", cpu_rdata, 0);

    // Wishbone partial write, then readback.
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h3000_0040;
    wb_sel = 4'b0011; wb_wdat = 32'h1234_5678;
    #1;
    chk("t2_addr", addr0, 9'h010);
    chk("t2_wmask", wmask0, 4'b0011);
    chk("t2_web", web0, 0);
    chk("t2_din", din0, 32'h1234_5678);
    @(posedge clk); #1;
    chk("t2_ack", wb_ack, 1);
    chk("t2_wdat0", wb_rdat, 0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    chk("t2_ack_once", wb_ack, 0);
    wb_acc(1'b0, 9'h010, '0, 4'hF, rd);
    chk("t2_readback", rd, 32'hDEAD_5678);

    // Simultaneous requests from reset: alternate, WB skipped while pending.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h001;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_0008;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t3_gnt%0d", k), cpu_gnt, exp_g[k]);
      chk($sformatf("t3_csb%0d", k), csb0, 0);
      chk($sformatf("t3_addr%0d", k), addr0, exp_g[k] ? 9'h001 : 9'h002);
      @(posedge clk); #1;
      chk($sformatf("t3_ack%0d", k), wb_ack, !exp_g[k]);
      chk($sformatf("t3_rv%0d", k), cpu_rvalid, exp_g[k]);
      @(negedge clk);
    end
    cpu_req = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (2) @(negedge clk);

    // Wishbone-only mode locks the core out; WB acks every other cycle.
    wb_only = 1'b1;
    cpu_req = 1'b1; cpu_addr = 9'h004;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_000C;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("t4_gnt%0d", k), cpu_gnt, 0);
      chk($sformatf("t4_csb%0d", k), csb0, k % 2);
      @(posedge clk); #1;
      chk($sformatf("t4_ack%0d", k), wb_ack, (k % 2) == 0);
      @(negedge clk);
    end
    cpu_req = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_only = 1'b0;
    repeat (2) @(negedge clk);

    // Reset landing between a WB grant and its ack drops the response.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_0040;
    #1;
    chk("t5_grant", csb0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_csb_rst", csb0, 1);
    @(posedge clk); #1;
    chk("t5_ack0", wb_ack, 0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    chk("t5_ack1", wb_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_idle", {csb0, web0, wmask0, addr0, din0 != 0, wb_ack, cpu_rvalid},
        {1'b1, 1'b1, 4'h0, 9'h000, 1'b0, 1'b0, 1'b0});
    cpu_acc(1'b0, 9'h010, '0, 4'hF, rd);
    chk("t5_read", rd, 32'hDEAD_5678);

    // Core back-to-back writes then reads.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 9'(i);
      cpu_wdata = 32'hA500_0000 + i;
      #1;
      chk($sformatf("t6_wgnt%0d", i), cpu_gnt, 1);
      @(posedge clk); #1;
      chk($sformatf("t6_wrdata%0d", i), cpu_rdata, 0);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_we = 1'b0; cpu_addr = 9'(i);
      #1;
      chk($sformatf("t6_rgnt%0d", i), cpu_gnt, 1);
      @(posedge clk); #1;
      chk($sformatf("t6_rdata%0d", i), cpu_rdata, 32'hA500_0000 + i);
    end
    cpu_req = 1'b0;

    // Concurrent random traffic against per-requester shadows.
    @(negedge clk);
    rv0 = n_rv;
    ack0 = n_ack;
    fork
      begin
        logic [31:0] r, d;
        logic [3:0] a, m;
        logic w;
        for (int i = 0; i < 12; i++) begin
          a = 4'($urandom_range(0, 15)); w = 1'($urandom); d = $urandom;
          m = 4'($urandom_range(1, 15));
          cpu_acc(w, {5'h10, a}, d, m, r);
          if (w) sb_cpu[a] = merge(sb_cpu[a], d, m);
          else chk("rnd_cpu", r, sb_cpu[a]);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        logic [31:0] r, d;
        logic [3:0] a, m;
        logic w;
        for (int j = 0; j < 12; j++) begin
          a = 4'($urandom_range(0, 15)); w = 1'($urandom); d = $urandom;
          m = 4'($urandom_range(1, 15));
          wb_acc(w, {5'h18, a}, d, m, r);
          if (w) sb_wb[a] = merge(sb_wb[a], d, m);
          else chk("rnd_wb", r, sb_wb[a]);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join
    repeat (2) @(negedge clk);
    chk("rnd_rv_count", n_rv - rv0, 12);
    chk("rnd_ack_count", n_ack - ack0, 12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
